// File: rtl/gcn_layer_sequencer.sv
// gcn_layer_sequencer: runs one GCN layer pass, kicking the transformation block and streaming product rows to aggregation
// Ports:
//   clk, reset (async, active-low)     clocking and reset
//   start                              layer request, honoured in IDLE/ERROR
//   trans_start / done_trans           start pulse to / completion from the transformation block
//   read_row / fm_wm_row               row select into / row data from the product memory
//   row_data, row_index, row_valid,
//   row_ready                          registered row stream to aggregation (valid/ready)
//   busy, done, error                  status: active, one-cycle completion, sticky watchdog timeout
module gcn_layer_sequencer #(
  parameter int FEATURE_ROWS   = 6,
  parameter int WEIGHT_COLS    = 3,
  parameter int DOT_PROD_WIDTH = 16,
  parameter int ROW_WIDTH      = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMER_WIDTH    = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      trans_start,
  input  logic                      done_trans,
  output logic [ROW_WIDTH-1:0]      read_row,
  input  logic [DOT_PROD_WIDTH-1:0] fm_wm_row [WEIGHT_COLS],
  output logic [DOT_PROD_WIDTH-1:0] row_data [WEIGHT_COLS],
  output logic [ROW_WIDTH-1:0]      row_index,
  output logic                      row_valid,
  input  logic                      row_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);
  typedef enum logic [2:0] {IDLE, KICK, WAIT, FETCH, PRESENT, DONE, ERROR} state_t;
  state_t state, state_n;
  logic [TIMER_WIDTH-1:0] timer;
  logic last, expired;
  assign last    = row_index == ROW_WIDTH'(FEATURE_ROWS - 1);
  assign expired = timer == TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  // error is only ever set on entry to ERROR and only cleared by leaving it,
  // so the sticky flag is exactly the ERROR state.
  always_comb begin
    state_n     = state;
    trans_start = state == KICK;
    row_valid   = state == PRESENT;
    done        = state == DONE;
    error       = state == ERROR;
    busy        = state != IDLE && state != ERROR;
    case (state)
      IDLE, ERROR: state_n = start ? KICK : state;
      KICK:        state_n = WAIT;
      WAIT:        state_n = done_trans ? FETCH : expired ? ERROR : WAIT;
      FETCH:       state_n = PRESENT;
      PRESENT:     state_n = row_ready ? (last ? DONE : FETCH) : PRESENT;
      DONE:        state_n = IDLE;
      default:     state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      timer     <= '0;
      read_row  <= '0;
      row_index <= '0;
      row_data  <= '{default: '0};
    end else begin
      if (state == KICK) begin
        timer    <= '0;
        read_row <= '0;
      end
      if (state == WAIT) timer <= timer + 1'b1;
      if (state == FETCH) begin
        row_data  <= fm_wm_row;
        row_index <= read_row;
      end
      if (state == PRESENT && row_ready) read_row <= last ? '0 : read_row + 1'b1;
    end
endmodule

// File: tb/tb_gcn_layer_sequencer.sv
// tb_gcn_layer_sequencer: directed and randomized passes checked against a row-stream reference model
module tb_gcn_layer_sequencer;
  localparam int R = 6, C = 3, W = 16, RW = 3, TO = 32;
  logic clk = 0, reset, start, done_trans, row_ready;
  logic trans_start, row_valid, busy, done, error;
  logic [RW-1:0] read_row, row_index;
  logic [W-1:0] fm_wm_row [C], row_data [C];
  logic [W-1:0] mem [R][C];
  int passed = 0, fails = 0, total = 0;
  int exp_idx, n_ts, n_done, cyc = 0, last_hs, stalls, hold;
  always #5 clk = ~clk;
  always_comb
    for (int c = 0; c < C; c++)
      fm_wm_row[c] = (int'(read_row) < R) ? mem[int'(read_row)][c] : 16'hdead;
  gcn_layer_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .trans_start(trans_start),
    .done_trans(done_trans), .read_row(read_row), .fm_wm_row(fm_wm_row),
    .row_data(row_data), .row_index(row_index), .row_valid(row_valid),
    .row_ready(row_ready), .busy(busy), .done(done), .error(error));
  function automatic logic [47:0] pk_data();
    return {row_data[0], row_data[1], row_data[2]};
  endfunction
  function automatic logic [47:0] mem_row(input int i);
    return (i < R) ? {mem[i][0], mem[i][1], mem[i][2]} : 48'hx;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_trans_start"}, trans_start, 0);
    chk({tag, "_read_row"}, read_row, 0);
    chk({tag, "_row_data"}, pk_data(), 0);
    chk({tag, "_row_index"}, row_index, 0);
    chk({tag, "_row_valid"}, row_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
  endtask
  // Observe the handshake just before the edge, then check what the edge produced.
  task automatic tick();
    bit hs, pv, pr, fin;
    logic [47:0] pd;
    logic [RW-1:0] pi, prr;
    hs = row_valid && row_ready;
    fin = 0;
    if (trans_start) n_ts++;
    if (done) n_done++;
    if (row_valid && !row_ready) stalls++;
    if (hs) begin
      chk("row_index", row_index, exp_idx);
      chk("row_data", pk_data(), mem_row(exp_idx));
      if (exp_idx > 0) chk("row_gap", cyc - last_hs, 2 + stalls);
      fin = exp_idx == R - 1;
      exp_idx++;
      last_hs = cyc;
      stalls = 0;
    end
    pv = row_valid; pr = row_ready; pd = pk_data(); pi = row_index; prr = read_row;
    @(posedge clk);
    #1;
    cyc++;
    chk("done_pulse", done, fin);
    chk("read_row_range", read_row < R, 1);
    if (pv && !pr) begin
      chk("hold_valid", row_valid, 1);
      chk("hold_data", pk_data(), pd);
      chk("hold_index", row_index, pi);
      chk("hold_read_row", read_row, prr);
    end
  endtask
  task automatic run_pass(input int dly, input bit rnd, input int hold_row, input int abort_row, input bit pattern);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        mem[r][c] = pattern ? W'(r * 3 + c) : W'($urandom);
    exp_idx = 0; n_ts = 0; n_done = 0; stalls = 0; hold = 0;
    start = 1;
    tick();
    start = 0;
    chk("kick_trans_start", trans_start, 1);
    chk("kick_error_clear", error, 0);
    chk("kick_busy", busy, 1);
    tick();
    for (int i = 0; i < dly; i++) begin
      start = i == 1;
      tick();
    end
    start = 0;
    done_trans = 1;
    tick();
    done_trans = 0;
    chk("fetch_no_valid", row_valid, 0);
    chk("fetch_no_error", error, 0);
    chk("fetch_busy", busy, 1);
    for (int g = 0; g < 300 && n_done == 0; g++) begin
      if (abort_row >= 0 && row_valid && int'(row_index) == abort_row) begin
        row_ready = 0;
        #2 reset = 0;
        #1 chk_zero("abort");
        tick();
        tick();
        chk("abort_no_done", n_done, 0);
        @(negedge clk) reset = 1;
        return;
      end
      if (row_valid && int'(row_index) == hold_row && hold < 7) begin
        row_ready = 0;
        hold++;
      end else row_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
    end
    chk("rows", exp_idx, R);
    chk("trans_pulses", n_ts, 1);
    chk("done_count", n_done, 1);
    chk("busy_after", busy, 0);
    chk("done_after", done, 0);
    row_ready = 0;
  endtask
  initial begin
    reset = 0; start = 0; done_trans = 0; row_ready = 0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        mem[r][c] = '0;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk) reset = 1;
    @(posedge clk);
    #1;
    run_pass(19, 0, -1, -1, 1);
    run_pass(5, 0, 2, -1, 0);
    n_ts = 0;
    start = 1;
    tick();
    start = 0;
    row_ready = 1;
    tick();
    for (int i = 0; i < TO - 1; i++) tick();
    chk("wd_busy_before", busy, 1);
    chk("wd_error_before", error, 0);
    tick();
    chk("wd_error", error, 1);
    chk("wd_busy", busy, 0);
    chk("wd_no_valid", row_valid, 0);
    done_trans = 1;
    repeat (3) tick();
    done_trans = 0;
    chk("wd_error_sticky", error, 1);
    chk("wd_no_valid_sticky", row_valid, 0);
    chk("wd_one_kick", n_ts, 1);
    row_ready = 0;
    run_pass(7, 1, -1, -1, 0);
    run_pass(TO - 1, 1, -1, -1, 0);
    run_pass(3, 0, -1, 4, 0);
    run_pass(10, 1, -1, -1, 0);
    repeat (3) run_pass($urandom_range(2, TO - 1), 1, $urandom_range(0, R - 1), -1, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
